// File: rtl/timer_pkg.sv
// Shared types for the timer block: FSM state encoding and mode constants.
// Latency: n/a (types only).
// Backpressure: n/a.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/tmr_cnt.sv
// Wrapping up-counter with enable, synchronous clear and terminal compare.
// Latency: count updates one cycle after an enabled edge; at_term is combinational on cnt.
// Backpressure: none; the enable input is the only hold mechanism.
//
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   clr           synchronous clear (wins over enable)
//   en            advance the count this cycle
//   term          terminal count; the counter wraps to 0 after reaching it
//   cnt           registered count
//   at_term       high while cnt equals term
module tmr_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] term,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 at_term
);

  assign at_term = (cnt == term);

  // Explicit wrap at term, so an all-ones term never relies on carry-out.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_term ? '0 : cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// One-shot / periodic timer: IDLE -> RUN -> (DONE | wrap) with start, stop and reject handling.
// Latency: all outputs registered; start at cycle 0 gives cnt_o=0 at cycle 1, first tick at P+2.
// Backpressure: none; start_i/stop_i are level inputs sampled every cycle.
//
// Optional feature macro: TIMER_PRESCALE_EN adds the PRE_WIDTH parameter, the prescale_i
// port and a divider that enables counting once every D+1 clocks.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i, stop_i       arm/restart, abort (stop wins)
//   mode_i, period_i      one-shot(0)/periodic(1) and terminal count, latched on start
//   prescale_i            divider D, latched on start (prescale build only)
//   cnt_o                 current count
//   busy_o, done_o        state levels for RUN and DONE
//   tick_o, err_o         single-cycle pulses: terminal wrap, rejected start
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = 8
`ifdef TIMER_PRESCALE_EN
  ,
  parameter int PRE_WIDTH = 4
`endif
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 stop_i,
  input  logic                 mode_i,
  input  logic [CNT_WIDTH-1:0] period_i,
`ifdef TIMER_PRESCALE_EN
  input  logic [PRE_WIDTH-1:0] prescale_i,
`endif
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 busy_o,
  output logic                 tick_o,
  output logic                 done_o,
  output logic                 err_o
);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] period_q;
  logic                 mode_q;
  logic                 tick_q, tick_nxt;
  logic                 err_q, err_nxt;
  logic                 start_ok;
  logic                 cnt_clr, cnt_en;
  logic                 pre_en;
  logic                 at_term;
  logic [CNT_WIDTH-1:0] cnt;

  // A start with a zero period is rejected outright.
  assign start_ok = start_i && (period_i != '0);

`ifdef TIMER_PRESCALE_EN
  logic [PRE_WIDTH-1:0] pre_div_q;
  logic [PRE_WIDTH-1:0] pre_q;

  // Divider runs 0..D in RUN; the count advances on the cycle it sits at D.
  assign pre_en = (pre_q == pre_div_q);

  always_ff @(posedge clk_i) begin
    if (rst_i || stop_i || start_ok) begin
      pre_q <= '0;
    end else if (state == ST_RUN) begin
      pre_q <= pre_en ? '0 : pre_q + PRE_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pre_div_q <= '0;
    end else if (!stop_i && start_ok) begin
      pre_div_q <= prescale_i;
    end
  end
`else
  assign pre_en = 1'b1;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      period_q <= '0;
      mode_q   <= MODE_ONESHOT;
    end else if (!stop_i && start_ok) begin
      period_q <= period_i;
      mode_q   <= mode_i;
    end
  end

  // Priority: stop > accepted start > (rejected start flag + normal counting).
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    tick_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (stop_i) begin
      state_nxt = ST_IDLE;
      cnt_clr   = 1'b1;
    end else if (start_ok) begin
      state_nxt = ST_RUN;
      cnt_clr   = 1'b1;
    end else begin
      err_nxt = start_i;
      if (state == ST_RUN) begin
        cnt_en = pre_en;
        if (pre_en && at_term) begin
          tick_nxt = 1'b1;
          if (mode_q != MODE_PERIODIC) begin
            state_nxt = ST_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      tick_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tick_q <= tick_nxt;
      err_q  <= err_nxt;
    end
  end

  tmr_cnt #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_cnt (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .term   (period_q),
    .cnt    (cnt),
    .at_term(at_term)
  );

  assign cnt_o  = cnt;
  assign busy_o = (state == ST_RUN);
  assign done_o = (state == ST_DONE);
  assign tick_o = tick_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: vector table, directed corner sequences,
// and randomized traffic against an elapsed-time reference model.
module tb_timer_ctrl;

  localparam int CW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mode = 1'b0;
  logic [CW-1:0] period = '0;
  logic [PW-1:0] prescale = '0;
  logic [CW-1:0] cnt_o;
  logic          busy_o, tick_o, done_o, err_o;

  always #5 clk = ~clk;

  timer_ctrl #(
    .CNT_WIDTH(CW)
`ifdef TIMER_PRESCALE_EN
    ,
    .PRE_WIDTH(PW)
`endif
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .start_i   (start),
    .stop_i    (stop),
    .mode_i    (mode),
    .period_i  (period),
`ifdef TIMER_PRESCALE_EN
    .prescale_i(prescale),
`endif
    .cnt_o     (cnt_o),
    .busy_o    (busy_o),
    .tick_o    (tick_o),
    .done_o    (done_o),
    .err_o     (err_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks how many RUN clocks have elapsed since the last
  // start (m_k); the count and the wrap events follow from integer division.
  int     m_st = 0;      // 0 idle, 1 running, 2 finished
  longint m_p = 0;
  int     m_mode = 0;
  longint m_d = 0;
  longint m_k = 0;
  int     m_tick = 0;
  int     m_err = 0;

  function automatic longint exp_cnt();
    if (m_st == 1) return (m_k / (m_d + 1)) % (m_p + 1);
    return 0;
  endfunction

  task automatic model_step();
    m_tick = 0;
    m_err  = 0;
    if (rst) begin
      m_st = 0; m_p = 0; m_mode = 0; m_d = 0; m_k = 0;
    end else if (stop) begin
      m_st = 0; m_k = 0;
    end else if (start && period != 0) begin
      m_st = 1; m_k = 0;
      m_p = longint'(period);
      m_mode = int'(mode);
`ifdef TIMER_PRESCALE_EN
      m_d = longint'(prescale);
`else
      m_d = 0;
`endif
    end else begin
      m_err = int'(start);
      if (m_st == 1) begin
        m_k++;
        // Another full (P+1)-step period of enabled cycles has just elapsed.
        if ((m_k % (m_d + 1)) == 0 && ((m_k / (m_d + 1)) % (m_p + 1)) == 0) begin
          m_tick = 1;
          if (m_mode == 0) m_st = 2;
        end
      end
    end
  endtask

  logic [CW-1:0] o_cnt;
  logic          o_busy, o_tick, o_done, o_err;

  // One clock: drive inputs, sample outputs on the falling edge, then advance.
  task automatic cyc(input logic r, input logic s, input logic t, input logic md,
                     input logic [CW-1:0] p, input bit do_model);
    rst = r; start = s; stop = t; mode = md; period = p;
    @(negedge clk);
    o_cnt = cnt_o; o_busy = busy_o; o_tick = tick_o; o_done = done_o; o_err = err_o;
    if (do_model) begin
      chk("model_cnt",  longint'(cnt_o),  exp_cnt());
      chk("model_busy", longint'(busy_o), longint'(m_st == 1));
      chk("model_tick", longint'(tick_o), longint'(m_tick));
      chk("model_done", longint'(done_o), longint'(m_st == 2));
      chk("model_err",  longint'(err_o),  longint'(m_err));
    end
    @(posedge clk);
    model_step();
    #1;
  endtask

  typedef struct {
    logic          s, t, md;
    logic [CW-1:0] p;
    logic [CW-1:0] cnt;
    logic          busy, tick, done, err;
  } vec_t;

  function automatic vec_t mk(logic s, logic t, logic md, logic [CW-1:0] p,
                              logic [CW-1:0] c, logic b, logic tk, logic d, logic e);
    vec_t v;
    v.s = s; v.t = t; v.md = md; v.p = p;
    v.cnt = c; v.busy = b; v.tick = tk; v.done = d; v.err = e;
    return v;
  endfunction

  vec_t tbl[14];

  initial begin
    // Row i: inputs held during cycle i, outputs expected during cycle i.
    tbl[0]  = mk(1, 0, 0, 3, 0, 0, 0, 0, 0);  // one-shot P=3 start, reset state seen
    tbl[1]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 2, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 3, 1, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);  // wrap: tick + done
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 0);  // done holds; stop
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);  // zero-period start
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1);  // err pulse, still idle
    tbl[9]  = mk(1, 0, 1, 4, 0, 0, 0, 0, 0);  // periodic P=4 start
    tbl[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0);  // rejected start while running
    tbl[11] = mk(0, 0, 0, 0, 1, 1, 0, 0, 1);  // counting continued, err pulse
    tbl[12] = mk(0, 1, 0, 0, 2, 1, 0, 0, 0);  // stop
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);

    for (int i = 0; i < 14; i++) begin
      cyc(0, tbl[i].s, tbl[i].t, tbl[i].md, tbl[i].p, 0);
      chk($sformatf("tbl%0d_cnt", i),  longint'(o_cnt),  longint'(tbl[i].cnt));
      chk($sformatf("tbl%0d_busy", i), longint'(o_busy), longint'(tbl[i].busy));
      chk($sformatf("tbl%0d_tick", i), longint'(o_tick), longint'(tbl[i].tick));
      chk($sformatf("tbl%0d_done", i), longint'(o_done), longint'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i),  longint'(o_err),  longint'(tbl[i].err));
    end

    // Periodic P=2: ticks at cycles 4, 7, 10.
    for (int c = 0; c < 12; c++) begin
      cyc(0, c == 0, 0, 1, 2, 1);
      chk($sformatf("per_tick_c%0d", c), longint'(o_tick), longint'(c == 4 || c == 7 || c == 10));
    end
    cyc(0, 0, 1, 0, 0, 1);

    // Periodic P=2 with stop at cycle 8: idle at 9, no further ticks.
    for (int c = 0; c < 13; c++) begin
      cyc(0, c == 0, c == 8, 1, 2, 1);
      chk($sformatf("pstop_tick_c%0d", c), longint'(o_tick), longint'(c == 4 || c == 7));
      if (c == 9) begin
        chk("pstop_busy", longint'(o_busy), 0);
        chk("pstop_cnt", longint'(o_cnt), 0);
      end
    end

    // Start and stop together while running: stop wins.
    for (int c = 0; c < 5; c++) begin
      cyc(0, c == 0 || c == 3, c == 3, 1, 5, 1);
      if (c == 4) begin
        chk("coll_busy", longint'(o_busy), 0);
        chk("coll_cnt", longint'(o_cnt), 0);
      end
    end

    // Restart exactly at terminal count: no tick, count restarts.
    for (int c = 0; c < 6; c++) begin
      cyc(0, c == 0 || c == 3, 0, 1, (c == 3) ? 8'd4 : 8'd2, 1);
      if (c == 3) chk("term_restart_cnt_before", longint'(o_cnt), 2);
      if (c == 4) begin
        chk("term_restart_tick", longint'(o_tick), 0);
        chk("term_restart_cnt", longint'(o_cnt), 0);
        chk("term_restart_busy", longint'(o_busy), 1);
      end
      if (c == 5) chk("term_restart_cnt_next", longint'(o_cnt), 1);
    end
    cyc(0, 0, 1, 0, 0, 1);

    // Reset mid-run at cnt=5 (P=10), then a clean one-shot P=3.
    for (int c = 0; c < 8; c++) begin
      cyc(c == 6, c == 0, 0, 0, 10, 1);
      if (c == 6) chk("rstmid_cnt_at_rst", longint'(o_cnt), 5);
      if (c == 7) begin
        chk("rstmid_cnt", longint'(o_cnt), 0);
        chk("rstmid_busy", longint'(o_busy), 0);
        chk("rstmid_tick", longint'(o_tick), 0);
        chk("rstmid_done", longint'(o_done), 0);
      end
    end
    for (int c = 0; c < 6; c++) begin
      cyc(0, c == 0, 0, 0, 3, 1);
      if (c >= 1 && c <= 4) chk($sformatf("post_rst_cnt_c%0d", c), longint'(o_cnt), longint'(c - 1));
      if (c == 5) begin
        chk("post_rst_tick", longint'(o_tick), 1);
        chk("post_rst_done", longint'(o_done), 1);
        chk("post_rst_busy", longint'(o_busy), 0);
      end
    end
    cyc(0, 0, 1, 0, 0, 1);

    // All-ones period: reaches 255, then wraps to 0 with tick and done.
    for (int c = 0; c < 258; c++) begin
      cyc(0, c == 0, 0, 0, 8'hFF, 1);
      if (c == 256) chk("max_cnt", longint'(o_cnt), 255);
      if (c == 257) begin
        chk("max_wrap_cnt", longint'(o_cnt), 0);
        chk("max_wrap_tick", longint'(o_tick), 1);
        chk("max_wrap_done", longint'(o_done), 1);
      end
    end
    cyc(0, 0, 1, 0, 0, 1);

`ifdef TIMER_PRESCALE_EN
    // D=1, P=1 periodic: count steps every 2 clocks, tick every 4.
    prescale = 4'd1;
    for (int c = 0; c < 14; c++) begin
      cyc(0, c == 0, 0, 1, 1, 1);
      if (c >= 1) chk($sformatf("pre_cnt_c%0d", c), longint'(o_cnt), longint'(((c - 1) / 2) % 2));
      chk($sformatf("pre_tick_c%0d", c), longint'(o_tick), longint'(c >= 5 && ((c - 5) % 4) == 0));
    end
    cyc(0, 0, 1, 0, 0, 1);
    prescale = '0;
`endif

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic r, s, t, md;
      logic [CW-1:0] p;
      r  = ($urandom_range(0, 149) == 0);
      s  = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 24) == 0);
      md = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) p = '0;
      else if ($urandom_range(0, 9) == 0) p = CW'($urandom_range(1, 255));
      else p = CW'($urandom_range(1, 5));
`ifdef TIMER_PRESCALE_EN
      prescale = PW'($urandom_range(0, 2));
`endif
      cyc(r, s, t, md, p, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
